// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// multi-cycle mul/div freezes for a 5-stage pipeline, plus a stall counter.
module hazard_ctrl #(
   parameter int unsigned MDU_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  Rs1_IF_ID,
   input  logic [4:0]  Rs2_IF_ID,
   input  logic [4:0]  Rd_ID_EXE,
   input  logic        mem_read_ID_EXE,
   input  logic        branch_taken_EXE,
   input  logic        mdu_start_ID_EXE,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_exe_write,
   output logic        if_id_flush,
   output logic        id_exe_flush,
   output logic        exe_mem_bubble,
   output logic        mdu_done,
   output logic [15:0] stall_cycles
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   // The freeze cycle in RUN counts as the first of MDU_LATENCY cycles and
   // the done cycle as the last, so the wait state starts at latency-2.
   localparam logic [3:0] CNT_INIT = 4'(MDU_LATENCY - 32'd2);

   state_t      state_q, state_d;
   state_t      state_eff_s;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        load_use_s;

   // Load-use hazard: the load in EXE writes a register the ID instruction reads.
   always_comb begin
      load_use_s = mem_read_ID_EXE && (Rd_ID_EXE != 5'd0) &&
                   ((Rd_ID_EXE == Rs1_IF_ID) || (Rd_ID_EXE == Rs2_IF_ID));
   end

   // Hazard decision and next-state logic; while rst is high the RUN rules apply.
   always_comb begin
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      id_exe_write   = 1'b1;
      if_id_flush    = 1'b0;
      id_exe_flush   = 1'b0;
      exe_mem_bubble = 1'b0;
      mdu_done       = 1'b0;
      state_d        = state_q;
      cnt_d          = cnt_q;
      state_eff_s    = rst ? RUN : state_q;

      case (state_eff_s)
         RUN: begin
            if (mdu_start_ID_EXE) begin
               pc_write       = 1'b0;
               if_id_write    = 1'b0;
               id_exe_write   = 1'b0;
               exe_mem_bubble = 1'b1;
               state_d        = MDU_WAIT;
               cnt_d          = CNT_INIT;
            end else if (branch_taken_EXE) begin
               // A taken branch squashes the ID instruction, so any load-use
               // match against it is irrelevant.
               if_id_flush  = 1'b1;
               id_exe_flush = 1'b1;
               pc_write     = 1'b1;
            end else if (load_use_s) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_exe_flush = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         MDU_WAIT: begin
            if (cnt_q != 4'd0) begin
               pc_write       = 1'b0;
               if_id_write    = 1'b0;
               id_exe_write   = 1'b0;
               exe_mem_bubble = 1'b1;
               cnt_d          = cnt_q - 4'd1;
            end else begin
               // mdu_start is still high for this same instruction; ignore it.
               mdu_done = 1'b1;
               state_d  = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Stall counter increments on every frozen-PC cycle and saturates.
   always_comb begin
      if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // State, counter and performance-counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         cnt_q          <= 4'd0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (latency 4, 2, 16)
// share the stimulus and are checked against a cycle-level reference model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic        mr, br, ms;
   logic [2:0][6:0]  o;   // {pc, ifw, idw, iff, idf, bub, done}
   logic [2:0][15:0] sc;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat [3] = '{4, 2, 16};
   int          busy [3];          // cycles of the current mul/div still to come
   int          m_stall [3];
   logic [6:0]  exp_o [3];
   logic [6:0]  obs [3];

   always #5 clk = ~clk;

   hazard_ctrl #(.MDU_LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst), .Rs1_IF_ID(rs1), .Rs2_IF_ID(rs2), .Rd_ID_EXE(rd),
      .mem_read_ID_EXE(mr), .branch_taken_EXE(br), .mdu_start_ID_EXE(ms),
      .pc_write(o[0][6]), .if_id_write(o[0][5]), .id_exe_write(o[0][4]),
      .if_id_flush(o[0][3]), .id_exe_flush(o[0][2]), .exe_mem_bubble(o[0][1]),
      .mdu_done(o[0][0]), .stall_cycles(sc[0]));

   hazard_ctrl #(.MDU_LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .Rs1_IF_ID(rs1), .Rs2_IF_ID(rs2), .Rd_ID_EXE(rd),
      .mem_read_ID_EXE(mr), .branch_taken_EXE(br), .mdu_start_ID_EXE(ms),
      .pc_write(o[1][6]), .if_id_write(o[1][5]), .id_exe_write(o[1][4]),
      .if_id_flush(o[1][3]), .id_exe_flush(o[1][2]), .exe_mem_bubble(o[1][1]),
      .mdu_done(o[1][0]), .stall_cycles(sc[1]));

   hazard_ctrl #(.MDU_LATENCY(16)) u_l16 (
      .clk(clk), .rst(rst), .Rs1_IF_ID(rs1), .Rs2_IF_ID(rs2), .Rd_ID_EXE(rd),
      .mem_read_ID_EXE(mr), .branch_taken_EXE(br), .mdu_start_ID_EXE(ms),
      .pc_write(o[2][6]), .if_id_write(o[2][5]), .id_exe_write(o[2][4]),
      .if_id_flush(o[2][3]), .id_exe_flush(o[2][2]), .exe_mem_bubble(o[2][1]),
      .mdu_done(o[2][0]), .stall_cycles(sc[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Expected outputs from the hazard rules, given the model's mul/div progress.
   function automatic logic [6:0] model_out(input int b, input logic r);
      logic lu;
      lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
      if (!r && b > 1)  return 7'b0000010;   // frozen inside a mul/div
      if (!r && b == 1) return 7'b1110001;   // final mul/div cycle
      if (ms)           return 7'b0000010;   // mul/div enters EXE
      if (br)           return 7'b1111100;   // taken branch flush
      if (lu)           return 7'b0010100;   // load-use bubble
      return 7'b1110000;
   endfunction

   // One clock: apply inputs, check at negedge, advance the model at posedge.
   task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic m, input logic b, input logic s);
      rst = r; rs1 = a1; rs2 = a2; rd = d; mr = m; br = b; ms = s;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         exp_o[k] = model_out(busy[k], r);
         obs[k]   = o[k];
         check($sformatf("outs_l%0d", lat[k]), 32'(o[k]), 32'(exp_o[k]));
         check($sformatf("stall_l%0d", lat[k]), 32'(sc[k]), 32'(m_stall[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            busy[k] = 0;
            m_stall[k] = 0;
         end else begin
            if (!exp_o[k][6]) m_stall[k] = (m_stall[k] < 65535) ? m_stall[k] + 1 : 65535;
            if (busy[k] > 0)  busy[k] = busy[k] - 1;
            else if (s)       busy[k] = lat[k] - 1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   int done_cnt [3];
   logic [7:0] done_mask;

   initial begin
      for (int k = 0; k < 3; k++) begin busy[k] = 0; m_stall[k] = 0; end
      do_reset();
      idle(1);
      check("reset_outs", 32'(obs[0]), 32'h70);
      check("reset_stall", 32'(sc[0]), 32'd0);

      // Load-use on rs2 for one cycle.
      step(1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
      check("loaduse_outs", 32'(obs[0]), 32'h14);
      idle(1);
      check("loaduse_after", 32'(obs[0]), 32'h70);
      check("loaduse_stall", 32'(sc[0]), 32'd1);

      // Load into x0 never stalls.
      step(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
      check("x0_load", 32'(obs[1]), 32'h70);

      // Taken branch overrides a load-use match.
      step(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
      check("branch_prio", 32'(obs[2]), 32'h7C);
      idle(1);
      check("branch_stall", 32'(sc[2]), 32'd1);

      // Mul/div with start held 4 cycles, then 12 idle cycles.
      do_reset();
      for (int k = 0; k < 3; k++) done_cnt[k] = 0;
      done_mask = 8'd0;
      for (int c = 0; c < 16; c++) begin
         step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, (c < 4) ? 1'b1 : 1'b0);
         for (int k = 0; k < 3; k++) done_cnt[k] += int'(obs[k][0]);
         if (c < 8) done_mask[c] = obs[0][0];
      end
      check("mdu4_done_at3", 32'(done_mask), 32'h08);
      check("mdu4_stall", 32'(sc[0]), 32'd3);
      check("mdu2_stall", 32'(sc[1]), 32'd2);
      check("mdu2_dones", 32'(done_cnt[1]), 32'd2);
      check("mdu16_stall", 32'(sc[2]), 32'd15);
      check("mdu16_dones", 32'(done_cnt[2]), 32'd1);

      // Two back-to-back mul/div on the latency-4 instance.
      do_reset();
      done_mask = 8'd0;
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
         done_mask[c] = obs[0][0];
      end
      idle(1);
      check("b2b_done_mask", 32'(done_mask), 32'h88);
      check("b2b_stall", 32'(sc[0]), 32'd6);

      // Reset in cycle 1 of a mul/div aborts it.
      do_reset();
      step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
      step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) done_cnt[k] = 0;
      for (int c = 0; c < 20; c++) begin
         idle(1);
         for (int k = 0; k < 3; k++) done_cnt[k] += int'(obs[k][0]);
      end
      check("abort_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);
      check("abort_stall", 32'(sc[0]), 32'd0);
      check("abort_outs", 32'(obs[0]), 32'h70);

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end

      // Saturation: continuous load-use stall past 65535 cycles.
      do_reset();
      for (int i = 0; i < 65540; i++) step(1'b0, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("sat_l4", 32'(sc[0]), 32'hFFFF);
      check("sat_l16", 32'(sc[2]), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LATENCY, default 4, the total number of cycles a mul/div instruction occupies EXE, legal range 2..16.
REQ-002 SHALL have ports, in this order:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- Rs1_IF_ID  in  5  rs1 of the instruction in ID.
- Rs2_IF_ID  in  5  rs2 of the instruction in ID.
- Rd_ID_EXE  in  5  rd of the instruction in EXE.
- mem_read_ID_EXE  in  1  the instruction in EXE is a load.
- branch_taken_EXE  in  1  the branch/jump resolved in EXE is taken.
- mdu_start_ID_EXE  in  1  the instruction in EXE is mul/div; held level while the pipeline is frozen.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_exe_write  out  1  ID/EXE register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_exe_flush  out  1  load a NOP into ID/EXE; also used for the load-use bubble.
- exe_mem_bubble  out  1  load a NOP into EXE/MEM.
- mdu_done  out  1  mul/div result valid this cycle.
- stall_cycles  out  16  performance counter.

Function
REQ-003 SHALL implement the FSM states RUN and MDU_WAIT, with a 4-bit down-counter cnt.
REQ-004 SHALL define load_use = mem_read_ID_EXE && Rd_ID_EXE!=0 && (Rd_ID_EXE==Rs1_IF_ID || Rd_ID_EXE==Rs2_IF_ID).
REQ-005 Default outputs SHALL be: pc_write=if_id_write=id_exe_write=1; if_id_flush=id_exe_flush=exe_mem_bubble=mdu_done=0.
REQ-006 RUN, priority 1, mdu_start_ID_EXE=1 (freeze):
- pc_write=if_id_write=id_exe_write=0, exe_mem_bubble=1.
- next state MDU_WAIT, cnt<=MDU_LATENCY-2.
REQ-007 RUN, priority 2, branch_taken_EXE=1:
- if_id_flush=1, id_exe_flush=1, pc_write=1.
- load_use is ignored in this cycle.
REQ-008 RUN, priority 3, load_use=1: pc_write=0, if_id_write=0, id_exe_flush=1 (one bubble, one cycle only, since the load then leaves EXE).
REQ-009 MDU_WAIT with cnt!=0:
- freeze outputs as in REQ-006.
- cnt<=cnt-1.
- branch_taken_EXE, load_use and mdu_start_ID_EXE are ignored.
REQ-010 MDU_WAIT with cnt==0:
- mdu_done=1 and default enables, so the pipeline advances.
- next state RUN.
- mdu_start_ID_EXE is ignored in this cycle because it still belongs to the same instruction.
REQ-011 Mul/div latency SHALL be exactly MDU_LATENCY cycles from first mdu_start_ID_EXE=1 in RUN to mdu_done=1, inclusive, with exactly MDU_LATENCY-1 frozen cycles. For MDU_LATENCY=2 this is RUN (freeze), then MDU_WAIT with cnt=0 (done).
REQ-012 Back-to-back mul/div SHALL work: mdu_start_ID_EXE=1 in the first RUN cycle after mdu_done starts a new MDU_LATENCY sequence with no gap cycle.
REQ-013 stall_cycles SHALL increment by 1 on every edge where pc_write=0, and SHALL saturate at 16'hFFFF with no wrap.
REQ-014 All outputs except stall_cycles SHALL be combinational from state, cnt and inputs.
REQ-015 Only state, cnt and stall_cycles SHALL be registered.

Reset
REQ-016 rst=1 at a clock edge SHALL set state=RUN, cnt=0 and stall_cycles=0, overriding all other activity.
REQ-017 Reset asserted mid-MDU_WAIT SHALL abort the sequence; mdu_done is never asserted for the aborted instruction.
REQ-018 While rst=1 the outputs SHALL follow the RUN-state rules on the current inputs; after reset release with idle inputs they are pc_write=if_id_write=id_exe_write=1, all flush/bubble/done signals 0, stall_cycles=0.

Verification
REQ-019 Load-use: mem_read=1, Rd_ID_EXE=5, Rs2_IF_ID=5 for 1 cycle -> pc_write=0, if_id_write=0, id_exe_flush=1 for exactly 1 cycle; stall_cycles 0->1.
REQ-020 x0 load: Rd_ID_EXE=0, Rs1_IF_ID=0, mem_read=1 -> no stall; all enables stay 1.
REQ-021 Branch beats load-use: branch_taken=1 together with a load_use match -> if_id_flush=id_exe_flush=1 and pc_write=1; stall_cycles unchanged.
REQ-022 Mul/div, MDU_LATENCY=4: mdu_start held 4 cycles -> freeze in cycles 0-2, mdu_done=1 in cycle 3 only, stall_cycles=3. Repeat with the parameter set to 2, then 16, to cover both range ends.
REQ-023 Back-to-back and abort:
- Two consecutive mul/div -> mdu_done at cycles 3 and 7, stall_cycles=6.
- rst pulsed in cycle 1 of a mul/div -> state RUN, stall_cycles=0, no mdu_done.
REQ-024 Saturation: force more than 65535 stall cycles -> stall_cycles holds 16'hFFFF.
